// File: rtl/uart_pkg.sv
// Shared UART definitions: drain FSM encoding, data width and the
// transmitter acknowledge timeout used by the Tx FIFO.
package uart_pkg;

    localparam int UART_DATA_W     = 8;
    localparam int TXE_ACK_TIMEOUT = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LO   = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_RDY  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port register array: one write port, one registered read port.
// Shared by the transmit and receive FIFOs.
module sync_fifo_mem #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_W     = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_wr_en,
    input  logic [DEPTH_LOG2-1:0] i_wr_addr,
    input  logic [DATA_W-1:0]     i_wr_data,
    input  logic                  i_rd_en,
    input  logic [DEPTH_LOG2-1:0] i_rd_addr,
    output logic [DATA_W-1:0]     o_rd_data
);

    logic [DATA_W-1:0] mem [1 << DEPTH_LOG2];

    // Storage is left unreset; only the read register has a defined reset value.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_rd_data <= '0;
        end else if (i_rd_en) begin
            o_rd_data <= mem[i_rd_addr];
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter, drained one byte per Tx-empty cycle.
// Optional level/half-empty outputs are enabled by `define UART_TX_FIFO_LEVEL_EN.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_W     = UART_DATA_W
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_wr,
    input  logic [DATA_W-1:0]   i_data,
    input  logic                i_flush,
    output logic                o_full,
    output logic                o_empty,
    output logic                o_ovf,
    input  logic                i_txe,
    output logic                o_tx_wr,
`ifdef UART_TX_FIFO_LEVEL_EN
    output logic [DEPTH_LOG2:0] o_level,
    output logic                o_half,
`endif
    output logic [DATA_W-1:0]   o_tx_data
);

    localparam int PTR_W = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [PTR_W-1:0] wptr, rptr, wptr_nxt, rptr_nxt;
    logic             push, pop, full_nxt, empty_nxt;
    tx_state_t        state, state_nxt;
    logic [2:0]       busy_cnt;

    // Transmitter handshake: o_tx_wr is a one-cycle strobe offered only while
    // i_txe (ready) is high; i_txe falling acknowledges, rising means ready again.

    always_comb push = i_wr & ~o_full & ~i_flush;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            busy_cnt <= 3'd0;
        end else begin
            state    <= state_nxt;
            busy_cnt <= (state == WAIT_BUSY) ? busy_cnt + 3'd1 : 3'd0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (pop) state_nxt = WAIT_LO;
            WAIT_LO:   state_nxt = WAIT_BUSY;
            WAIT_BUSY: begin
                if (!i_txe) begin
                    state_nxt = WAIT_RDY;
                end else if (busy_cnt == 3'(TXE_ACK_TIMEOUT - 1)) begin
                    state_nxt = IDLE;
                end
            end
            WAIT_RDY:  if (i_txe) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // The strobe is the WAIT_LO state itself, so it lines up with the read register.
    always_comb begin
        pop     = 1'b0;
        o_tx_wr = 1'b0;
        if (state == IDLE) begin
            pop = ~o_empty & i_txe & ~i_flush;
        end
        if (state == WAIT_LO) begin
            o_tx_wr = 1'b1;
        end
    end

    always_comb begin
        wptr_nxt = wptr;
        rptr_nxt = rptr;
        if (i_flush) begin
            wptr_nxt = '0;
            rptr_nxt = '0;
        end else begin
            if (push) wptr_nxt = wptr + PTR_ONE;
            if (pop)  rptr_nxt = rptr + PTR_ONE;
        end
        empty_nxt = (wptr_nxt == rptr_nxt);
        full_nxt  = (wptr_nxt[DEPTH_LOG2] != rptr_nxt[DEPTH_LOG2]) &&
                    (wptr_nxt[DEPTH_LOG2-1:0] == rptr_nxt[DEPTH_LOG2-1:0]);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wptr    <= '0;
            rptr    <= '0;
            o_full  <= 1'b0;
            o_empty <= 1'b1;
            o_ovf   <= 1'b0;
        end else begin
            wptr    <= wptr_nxt;
            rptr    <= rptr_nxt;
            o_full  <= full_nxt;
            o_empty <= empty_nxt;
            if (i_flush) begin
                o_ovf <= 1'b0;
            end else if (i_wr && o_full) begin
                o_ovf <= 1'b1;
            end
        end
    end

`ifdef UART_TX_FIFO_LEVEL_EN
    logic [PTR_W-1:0] level_nxt;

    always_comb level_nxt = wptr_nxt - rptr_nxt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_level <= '0;
            o_half  <= 1'b1;
        end else begin
            o_level <= level_nxt;
            o_half  <= (level_nxt <= PTR_W'(DEPTH / 2));
        end
    end
`endif

    sync_fifo_mem #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (DATA_W)
    ) u_mem (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_wr_en   (push),
        .i_wr_addr (wptr[DEPTH_LOG2-1:0]),
        .i_wr_data (i_data),
        .i_rd_en   (pop),
        .i_rd_addr (rptr[DEPTH_LOG2-1:0]),
        .o_rd_data (o_tx_data)
    );

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a small cycle-stepped transmitter model.
// Define UART_TX_FIFO_LEVEL_EN to also exercise o_level/o_half.
module tb_uart_tx_fifo;

    logic       clk;
    logic       rst_n;
    logic       i_wr;
    logic [7:0] i_data;
    logic       i_flush;
    logic       o_full;
    logic       o_empty;
    logic       o_ovf;
    logic       i_txe;
    logic       o_tx_wr;
    logic [7:0] o_tx_data;
`ifdef UART_TX_FIFO_LEVEL_EN
    logic [4:0] o_level;
    logic       o_half;
`endif

    int n_cmp = 0;
    int n_fail = 0;

    // tx_mode: 0 = i_txe driven by the test, 1 = ack 2 cycles after strobe,
    // ready 40 cycles later, 2 = fastest possible ack (drop next cycle, back after 1)
    int         tx_mode;
    int         cyc;
    int         drop_at;
    int         rise_at;
    int         width_err;
    logic       prev_wr;
    logic [7:0] got_q[$];
    int         stb_q[$];
    logic [7:0] exp_q[$];

    uart_tx_fifo dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_wr      (i_wr),
        .i_data    (i_data),
        .i_flush   (i_flush),
        .o_full    (o_full),
        .o_empty   (o_empty),
        .o_ovf     (o_ovf),
        .i_txe     (i_txe),
        .o_tx_wr   (o_tx_wr),
`ifdef UART_TX_FIFO_LEVEL_EN
        .o_level   (o_level),
        .o_half    (o_half),
`endif
        .o_tx_data (o_tx_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        if (o_tx_wr) begin
            if (prev_wr) width_err++;
            got_q.push_back(o_tx_data);
            stb_q.push_back(cyc);
            if (tx_mode == 1) begin
                drop_at = cyc + 2;
                rise_at = cyc + 42;
            end else if (tx_mode == 2) begin
                drop_at = cyc + 1;
                rise_at = cyc + 2;
            end
        end
        prev_wr = o_tx_wr;
        if (tx_mode != 0) i_txe = !(cyc >= drop_at && cyc < rise_at);
    endtask

    task automatic push_byte(input logic [7:0] b);
        i_wr   = 1'b1;
        i_data = b;
        cycle();
        i_wr   = 1'b0;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        i_wr    = 1'b0;
        i_flush = 1'b0;
        i_data  = 8'h00;
        tx_mode = 0;
        repeat (3) cycle();
        rst_n = 1'b1;
        got_q.delete();
        stb_q.delete();
        exp_q.delete();
        width_err = 0;
        prev_wr   = 1'b0;
        drop_at   = 0;
        rise_at   = 0;
    endtask

    task automatic test_reset();
        i_txe   = 1'b1;
        rst_n   = 1'b0;
        i_wr    = 1'b0;
        i_flush = 1'b0;
        i_data  = 8'h00;
        tx_mode = 0;
        repeat (3) cycle();
        n_cmp++; if (o_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", o_empty); end
        n_cmp++; if (o_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", o_full); end
        n_cmp++; if (o_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", o_ovf); end
        n_cmp++; if (o_tx_wr !== 1'b0) begin n_fail++; $display("FAIL reset_tx_wr: got %b want 0", o_tx_wr); end
        n_cmp++; if (o_tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h want 00", o_tx_data); end
`ifdef UART_TX_FIFO_LEVEL_EN
        n_cmp++; if (o_level !== 5'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", o_level); end
        n_cmp++; if (o_half !== 1'b1) begin n_fail++; $display("FAIL reset_half: got %b want 1", o_half); end
`endif
    endtask

    task automatic test_basic_drain();
        logic [7:0] g;
        do_reset();
        i_txe   = 1'b1;
        tx_mode = 1;
        exp_q = '{8'h55, 8'hA3, 8'h0F};
        push_byte(8'h55);
        push_byte(8'hA3);
        push_byte(8'h0F);
        repeat (200) cycle();
        n_cmp++; if (got_q.size() !== 3) begin n_fail++; $display("FAIL basic_count: got %0d want 3", got_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got_q.size()) ? got_q[i] : 8'hxx;
            n_cmp++; if (g !== exp_q[i]) begin n_fail++; $display("FAIL basic_byte%0d: got %h want %h", i, g, exp_q[i]); end
        end
        n_cmp++; if (width_err !== 0) begin n_fail++; $display("FAIL basic_pulse_width: got %0d long pulses want 0", width_err); end
        n_cmp++; if (o_empty !== 1'b1) begin n_fail++; $display("FAIL basic_empty: got %b want 1", o_empty); end
    endtask

    task automatic test_overflow();
        logic [7:0] g;
        do_reset();
        i_txe = 1'b0;
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(8'h10 + 8'(i));
            push_byte(8'h10 + 8'(i));
        end
        n_cmp++; if (o_full !== 1'b1) begin n_fail++; $display("FAIL ovf_full16: got %b want 1", o_full); end
        n_cmp++; if (o_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_before: got %b want 0", o_ovf); end
        push_byte(8'hEE);
        n_cmp++; if (o_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", o_ovf); end
        n_cmp++; if (o_full !== 1'b1) begin n_fail++; $display("FAIL ovf_full17: got %b want 1", o_full); end
        i_txe   = 1'b1;
        tx_mode = 1;
        repeat (760) cycle();
        n_cmp++; if (got_q.size() !== 16) begin n_fail++; $display("FAIL ovf_count: got %0d want 16", got_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got_q.size()) ? got_q[i] : 8'hxx;
            n_cmp++; if (g !== exp_q[i]) begin n_fail++; $display("FAIL ovf_byte%0d: got %h want %h", i, g, exp_q[i]); end
        end
        n_cmp++; if (o_empty !== 1'b1) begin n_fail++; $display("FAIL ovf_empty_after: got %b want 1", o_empty); end
        n_cmp++; if (o_full !== 1'b0) begin n_fail++; $display("FAIL ovf_full_after: got %b want 0", o_full); end
        n_cmp++; if (o_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", o_ovf); end
    endtask

    task automatic test_flush();
        logic [7:0] g;
        do_reset();
        i_txe = 1'b0;
        for (int i = 0; i < 16; i++) push_byte(8'hC0 + 8'(i));
        push_byte(8'hDD);
        i_flush = 1'b1;
        i_wr    = 1'b1;
        i_data  = 8'hBB;
        cycle();
        i_flush = 1'b0;
        i_wr    = 1'b0;
        n_cmp++; if (o_empty !== 1'b1) begin n_fail++; $display("FAIL flush_empty: got %b want 1", o_empty); end
        n_cmp++; if (o_ovf !== 1'b0) begin n_fail++; $display("FAIL flush_ovf: got %b want 0", o_ovf); end
        n_cmp++; if (o_full !== 1'b0) begin n_fail++; $display("FAIL flush_full: got %b want 0", o_full); end
        i_txe   = 1'b1;
        tx_mode = 1;
        repeat (60) cycle();
        n_cmp++; if (got_q.size() !== 0) begin n_fail++; $display("FAIL flush_no_strobe: got %0d strobes want 0", got_q.size()); end
        push_byte(8'h3C);
        repeat (60) cycle();
        g = (got_q.size() > 0) ? got_q[0] : 8'hxx;
        n_cmp++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL flush_refill_count: got %0d want 1", got_q.size()); end
        n_cmp++; if (g !== 8'h3C) begin n_fail++; $display("FAIL flush_refill_byte: got %h want 3c", g); end
    endtask

    task automatic test_timeout();
        logic [7:0] g;
        do_reset();
        i_txe   = 1'b1;
        tx_mode = 0;
        exp_q = '{8'h11, 8'h22, 8'h33};
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        repeat (40) cycle();
        n_cmp++; if (got_q.size() !== 3) begin n_fail++; $display("FAIL timeout_count: got %0d want 3", got_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got_q.size()) ? got_q[i] : 8'hxx;
            n_cmp++; if (g !== exp_q[i]) begin n_fail++; $display("FAIL timeout_byte%0d: got %h want %h", i, g, exp_q[i]); end
        end
        for (int i = 1; i < 3; i++) begin
            int sp;
            sp = (i < stb_q.size()) ? stb_q[i] - stb_q[i-1] : -1;
            n_cmp++; if (sp !== 6) begin n_fail++; $display("FAIL timeout_spacing%0d: got %0d want 6", i, sp); end
        end
        n_cmp++; if (width_err !== 0) begin n_fail++; $display("FAIL timeout_pulse_width: got %0d long pulses want 0", width_err); end
        n_cmp++; if (o_empty !== 1'b1) begin n_fail++; $display("FAIL timeout_empty: got %b want 1", o_empty); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        i_txe   = 1'b1;
        tx_mode = 2;
        push_byte(8'hA1);
        push_byte(8'hB2);
        push_byte(8'hC3);
        repeat (30) cycle();
        n_cmp++; if (got_q.size() !== 3) begin n_fail++; $display("FAIL b2b_count: got %0d want 3", got_q.size()); end
        for (int i = 1; i < 3; i++) begin
            int sp;
            sp = (i < stb_q.size()) ? stb_q[i] - stb_q[i-1] : -1;
            n_cmp++; if (sp !== 4) begin n_fail++; $display("FAIL b2b_spacing%0d: got %0d want 4", i, sp); end
        end
    endtask

`ifdef UART_TX_FIFO_LEVEL_EN
    task automatic test_level();
        do_reset();
        i_txe = 1'b0;
        for (int i = 0; i < 9; i++) push_byte(8'h70 + 8'(i));
        n_cmp++; if (o_level !== 5'd9) begin n_fail++; $display("FAIL level_9: got %0d want 9", o_level); end
        n_cmp++; if (o_half !== 1'b0) begin n_fail++; $display("FAIL half_9: got %b want 0", o_half); end
        i_txe = 1'b1;
        cycle();
        i_txe = 1'b0;
        n_cmp++; if (o_level !== 5'd8) begin n_fail++; $display("FAIL level_8: got %0d want 8", o_level); end
        n_cmp++; if (o_half !== 1'b1) begin n_fail++; $display("FAIL half_8: got %b want 1", o_half); end
    endtask
`endif

    initial begin
        cyc       = 0;
        drop_at   = 0;
        rise_at   = 0;
        width_err = 0;
        prev_wr   = 1'b0;
        tx_mode   = 0;
        test_reset();
        test_basic_drain();
        test_overflow();
        test_flush();
        test_timeout();
        test_back_to_back();
`ifdef UART_TX_FIFO_LEVEL_EN
        test_level();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
